counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Controller for the 8-bit programmable counter datapath.
- Accepts a command over a valid/ready handshake: start value, end value, prescale, reload mode.
- Drives the counter's load, load-value, increment and output-enable controls so that it counts from start to end at a prescaled rate.
- Signals completion with a one-cycle pulse; in reload mode it repeats periodically, acting as a programmable timer.

Parameters:
- WIDTH, 8, width of the counter value and of the start/end fields.
- PRESCALE_W, 8, width of the prescale field. One increment is issued every prescale+1 clocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_start  in  WIDTH  value loaded into the counter.
- cmd_end  in  WIDTH  terminal counter value.
- cmd_prescale  in  PRESCALE_W  clocks per increment, minus 1.
- cmd_reload  in  1  1 = periodic (auto-reload), 0 = one-shot.
- abort  in  1  cancel the run in progress.
- cnt_value  in  WIDTH  current registered counter value, fed back from the counter.
- cnt_load  out  1  counter load strobe.
- cnt_load_val  out  WIDTH  value to load.
- cnt_inc  out  1  counter increment strobe.
- cnt_oe  out  1  counter output enable.
- busy  out  1  high in LOAD and COUNT.
- done  out  1  one-cycle pulse when the terminal value is reached.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over all inputs.
  - State goes to IDLE; presc_cnt=0; latched command fields=0.
  - Outputs: cmd_ready=1, cnt_load=0, cnt_load_val=0, cnt_inc=0, cnt_oe=0, busy=0, done=0.
  - Reset mid-run abandons the run with no done pulse.
- States: IDLE, LOAD, COUNT, HOLD.
- IDLE:
  - cmd_ready=1, cnt_oe=0.
  - On cmd_valid&cmd_ready, latch start, end, prescale and reload, then go to LOAD.
  - abort has no effect.
- LOAD (exactly 1 cycle):
  - cnt_load=1, cnt_load_val=start_q, cnt_oe=1, busy=1, cmd_ready=0.
  - Next state COUNT with presc_cnt=0.
- COUNT:
  - cnt_oe=1, busy=1, cmd_ready=0.
  - tick = (presc_cnt==prescale_q). presc_cnt resets to 0 on tick and increments otherwise.
  - On tick with cnt_value!=end_q: cnt_inc=1.
  - On tick with cnt_value==end_q: done=1 and no cnt_inc. Next state is LOAD if reload_q, else HOLD.
- HOLD:
  - cnt_oe=1 (final value stays visible), busy=0, cmd_ready=1.
  - An accepted command goes to LOAD.
  - abort goes to IDLE (display cleared).
- Abort during LOAD or COUNT:
  - Next state IDLE.
  - Suppresses cnt_inc and done in the same cycle. abort wins over tick.
- cnt_inc and done are combinational from state, presc_cnt, cnt_value and abort. All other outputs decode from registered state. cnt_load_val is registered: it holds start_q and is 0 after reset.
- Timing, with the LOAD cycle as cycle 0, P=prescale and N=(end-start) mod 2^WIDTH:
  - Tick k occurs at cycle k(P+1).
  - done occurs at cycle (N+1)(P+1), after N increments.
  - Reload period is (N+1)(P+1)+1 cycles.
- Wrap-around: end<start is legal. The counter wraps 2^WIDTH-1 -> 0, so N is computed mod 2^WIDTH.
- end==start gives done at the first tick with zero increments.
- The command fields are sampled only at acceptance; changes afterwards are ignored.
- cmd_valid while busy is simply not accepted. The requester holds its command until cmd_ready.
- The sequencer never asserts cnt_load and cnt_inc in the same cycle.

Decomposition:
- Shared package counter_pkg holds:
  - seq_state_t enum (IDLE, LOAD, COUNT, HOLD);
  - seq_cmd_t struct {start, end, prescale, reload};
  - COUNTER_WIDTH=8 and PRESCALE_WIDTH=8 constants.
- One natural sub-module: counter_prescaler.
  - Ports: clk, rst, clear, enable, prescale, tick.
  - Holds presc_cnt and the tick compare.
  - clear is asserted in LOAD and on abort.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0 except cmd_ready=1; state IDLE.
- One-shot, start=3, end=6, prescale=0 -> cnt_load at cycle 0, cnt_inc at cycles 1,2,3, done at cycle 4, then HOLD with cnt_oe=1, cnt_value=6, cmd_ready=1.
- Prescale and wrap, start=254, end=1, prescale=2 -> 3 increments (254->255->0->1) at cycles 3,6,9, done at cycle 12.
- Reload, start=0, end=0, prescale=1 -> done every 3 cycles (cycles 2,5,8,...), cnt_load 1 cycle after each done, cnt_inc never asserted.
- Abort on tick cycle during COUNT (start=10, end=20) -> no cnt_inc and no done that cycle, IDLE next cycle, cnt_oe=0; cmd_valid asserted during COUNT is not accepted until IDLE.
- rst mid-COUNT coincident with tick and match -> done=0 that cycle, next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared types and constants for the programmable counter subsystem.
//   Imported by the sequencer (counter_sequencer) and its prescaler
//   (counter_prescaler).
//
//   Contents:
//     COUNTER_WIDTH  - width of the counter value and the start/end fields
//     PRESCALE_WIDTH - width of the prescale field
//     seq_state_t    - sequencer FSM states
//     seq_cmd_t      - one counting command as seen by the datapath
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam int COUNTER_WIDTH  = 8;
    localparam int PRESCALE_WIDTH = 8;

    // IDLE  : display off, waiting for a command
    // LOAD  : one cycle, counter is loaded with the start value
    // COUNT : counter advances once every prescale+1 clocks
    // HOLD  : one-shot run finished, final value stays on the display
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    // "end" is a keyword, so the terminal value field is called end_val.
    typedef struct packed {
        logic [COUNTER_WIDTH-1:0]  start;
        logic [COUNTER_WIDTH-1:0]  end_val;
        logic [PRESCALE_WIDTH-1:0] prescale;
        logic                      reload;
    } seq_cmd_t;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
//   Divides the clock for the counter sequencer. While enabled, presc_cnt
//   runs 0..prescale and tick is high on the cycle where it equals
//   prescale, so one tick is produced every prescale+1 clocks.
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   synchronous active-high reset
//     clear    in   force presc_cnt to 0 (used on LOAD and on abort)
//     enable   in   count and produce ticks (sequencer in COUNT)
//     prescale in   PRESCALE_W  terminal value of presc_cnt
//     tick     out  combinational: enable & (presc_cnt == prescale)
// ---------------------------------------------------------------------------
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc_cnt_q;
    logic [PRESCALE_W-1:0] presc_cnt_d;

    assign tick = enable && (presc_cnt_q == prescale);

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (clear) begin
            presc_cnt_d = '0;
        end else if (enable) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops update together from values sampled before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule : counter_prescaler

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//   Controller for the 8-bit programmable counter datapath. A command
//   (start, end, prescale, reload) is taken over a valid/ready handshake.
//   The sequencer then loads the counter with start and increments it
//   once every prescale+1 clocks until the fed-back counter value equals
//   end, where it pulses done. In reload mode the run restarts
//   immediately from LOAD, which turns the block into a periodic timer;
//   in one-shot mode it parks in HOLD with the final value displayed.
//
//   Ports:
//     clk           in   system clock, rising edge
//     rst           in   synchronous active-high reset
//     cmd_valid     in   command present
//     cmd_ready     out  command can be accepted (IDLE or HOLD)
//     cmd_start     in   WIDTH       value loaded into the counter
//     cmd_end       in   WIDTH       terminal counter value
//     cmd_prescale  in   PRESCALE_W  clocks per increment, minus 1
//     cmd_reload    in   1 = periodic, 0 = one-shot
//     abort         in   cancel the run in progress
//     cnt_value     in   WIDTH       registered counter value (feedback)
//     cnt_load      out  counter load strobe (LOAD)
//     cnt_load_val  out  WIDTH       value to load (latched start)
//     cnt_inc       out  counter increment strobe (combinational)
//     cnt_oe        out  counter output enable
//     busy          out  high in LOAD and COUNT
//     done          out  one-cycle terminal pulse (combinational)
// ---------------------------------------------------------------------------
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH      = COUNTER_WIDTH,
    parameter int PRESCALE_W = PRESCALE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WIDTH-1:0]      cmd_start,
    input  logic [WIDTH-1:0]      cmd_end,
    input  logic [PRESCALE_W-1:0] cmd_prescale,
    input  logic                  cmd_reload,
    input  logic                  abort,

    input  logic [WIDTH-1:0]      cnt_value,
    output logic                  cnt_load,
    output logic [WIDTH-1:0]      cnt_load_val,
    output logic                  cnt_inc,
    output logic                  cnt_oe,
    output logic                  busy,
    output logic                  done
);

    // -----------------------------------------------------------------------
    // State and latched command
    // -----------------------------------------------------------------------
    seq_state_t            state_q;
    seq_state_t            state_d;

    logic [WIDTH-1:0]      start_q;
    logic [WIDTH-1:0]      end_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  reload_q;

    // Registered outputs, each a decode of the state being entered.
    logic                  cmd_ready_q;
    logic                  cnt_load_q;
    logic                  cnt_oe_q;
    logic                  busy_q;

    logic                  accept;
    logic                  tick;
    logic                  match;
    logic                  run_tick;
    logic                  presc_clear;

    // -----------------------------------------------------------------------
    // Prescaler
    // -----------------------------------------------------------------------
    // Cleared in LOAD so the first tick of a run lands exactly prescale+1
    // clocks after the load; cleared on abort so a later run starts clean.
    assign presc_clear = (state_q == LOAD) || abort;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clear    (presc_clear),
        .enable   (state_q == COUNT),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // -----------------------------------------------------------------------
    // Tick qualification
    // -----------------------------------------------------------------------
    // The command fields are sampled only here; the requester may change
    // them freely once the handshake is done.
    assign accept   = cmd_valid && cmd_ready_q;
    assign match    = (cnt_value == end_q);

    // abort and reset both win over a tick: no increment and no done pulse
    // may escape in the cycle that cancels the run.
    assign run_tick = tick && !abort && !rst;

    // cnt_inc and done are combinational so the strobe lines up with the
    // tick cycle. cnt_inc is only possible in COUNT while cnt_load is only
    // possible in LOAD, so the two never coincide.
    assign cnt_inc  = run_tick && !match;
    assign done     = run_tick && match;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // abort is meaningless here, nothing is running.
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = abort ? IDLE : COUNT;
            end
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick && match) begin
                    state_d = reload_q ? LOAD : HOLD;
                end
            end
            HOLD: begin
                // A completed handshake must be honoured, so a new command
                // takes precedence over a simultaneous abort.
                if (accept) begin
                    state_d = LOAD;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM registers, command latch and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= '0;
            end_q       <= '0;
            prescale_q  <= '0;
            reload_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            cnt_load_q  <= 1'b0;
            cnt_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                start_q    <= cmd_start;
                end_q      <= cmd_end;
                prescale_q <= cmd_prescale;
                reload_q   <= cmd_reload;
            end

            cmd_ready_q <= (state_d == IDLE) || (state_d == HOLD);
            cnt_load_q  <= (state_d == LOAD);
            cnt_oe_q    <= (state_d != IDLE);
            busy_q      <= (state_d == LOAD) || (state_d == COUNT);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cmd_ready    = cmd_ready_q;
    assign cnt_load     = cnt_load_q;
    assign cnt_load_val = start_q;
    assign cnt_oe       = cnt_oe_q;
    assign busy         = busy_q;

endmodule : counter_sequencer

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//   Self-checking bench for counter_sequencer. A behavioural 8-bit counter
//   closes the cnt_value feedback loop. Each run pushes its expected
//   per-cycle outputs (derived from the start/end/prescale timing rules)
//   into a scoreboard queue, which is popped and compared on falling edges.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int W  = 8;
    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_start;
    logic [W-1:0]  cmd_end;
    logic [PW-1:0] cmd_prescale;
    logic          cmd_reload;
    logic          abort;
    logic [W-1:0]  cnt_value;
    logic          cnt_load;
    logic [W-1:0]  cnt_load_val;
    logic          cnt_inc;
    logic          cnt_oe;
    logic          busy;
    logic          done;

    counter_sequencer #(
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_end      (cmd_end),
        .cmd_prescale (cmd_prescale),
        .cmd_reload   (cmd_reload),
        .abort        (abort),
        .cnt_value    (cnt_value),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_inc      (cnt_inc),
        .cnt_oe       (cnt_oe),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter datapath.
    always @(posedge clk) begin
        if (rst)           cnt_value <= '0;
        else if (cnt_load) cnt_value <= cnt_load_val;
        else if (cnt_inc)  cnt_value <= cnt_value + 8'd1;
    end

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        logic         load;
        logic         inc;
        logic         done;
        logic         oe;
        logic         busy;
        logic         ready;
        logic [W-1:0] lval;
        logic [W-1:0] val;
        bit           val_known;
        int           cyc;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    string cur_test = "";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected outputs of one run, LOAD cycle = cycle 0.
    // last_cycle < 0 pushes the full run; hold_cycles HOLD entries follow a
    // full one-shot run.
    task automatic push_run(input logic [W-1:0] s, input logic [W-1:0] e, input int p,
                            input bit prev_known, input logic [W-1:0] prev_val,
                            input int last_cycle, input int hold_cycles);
        logic [W-1:0] n;
        int           d;
        int           last;
        exp_t         x;
        n    = e - s;
        d    = (int'(n) + 1) * (p + 1);
        last = (last_cycle < 0) ? d : last_cycle;
        for (int c = 0; c <= last; c++) begin
            x.cyc  = c;
            x.lval = s;
            x.oe   = 1'b1;
            x.busy = 1'b1;
            x.ready = 1'b0;
            if (c == 0) begin
                x.load = 1'b1;
                x.inc  = 1'b0;
                x.done = 1'b0;
                x.val  = prev_val;
                x.val_known = prev_known;
            end else begin
                x.load = 1'b0;
                x.inc  = ((c % (p + 1)) == 0) && ((c / (p + 1)) <= int'(n));
                x.done = ((c % (p + 1)) == 0) && ((c / (p + 1)) == int'(n) + 1);
                x.val  = s + W'((c - 1) / (p + 1));
                x.val_known = 1'b1;
            end
            exp_q.push_back(x);
        end
        if (last == d) begin
            for (int h = 0; h < hold_cycles; h++) begin
                x.cyc  = d + 1 + h;
                x.load = 1'b0;
                x.inc  = 1'b0;
                x.done = 1'b0;
                x.oe   = 1'b1;
                x.busy = 1'b0;
                x.ready = 1'b1;
                x.lval = s;
                x.val  = e;
                x.val_known = 1'b1;
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic run_sb();
        exp_t  x;
        string t;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            x = exp_q.pop_front();
            t = $sformatf("%s.c%0d", cur_test, x.cyc);
            check({t, ".cnt_load"},     32'(cnt_load),     32'(x.load));
            check({t, ".cnt_inc"},      32'(cnt_inc),      32'(x.inc));
            check({t, ".done"},         32'(done),         32'(x.done));
            check({t, ".cnt_oe"},       32'(cnt_oe),       32'(x.oe));
            check({t, ".busy"},         32'(busy),         32'(x.busy));
            check({t, ".cmd_ready"},    32'(cmd_ready),    32'(x.ready));
            check({t, ".cnt_load_val"}, 32'(cnt_load_val), 32'(x.lval));
            check({t, ".load_inc_excl"}, 32'(cnt_load & cnt_inc), 32'd0);
            if (x.val_known) check({t, ".cnt_value"}, 32'(cnt_value), 32'(x.val));
        end
    endtask

    // Call at a falling edge: outputs expected in IDLE.
    task automatic check_idle(input string tag, input logic [W-1:0] lval);
        check({tag, ".cmd_ready"},    32'(cmd_ready),    32'd1);
        check({tag, ".cnt_load"},     32'(cnt_load),     32'd0);
        check({tag, ".cnt_inc"},      32'(cnt_inc),      32'd0);
        check({tag, ".done"},         32'(done),         32'd0);
        check({tag, ".cnt_oe"},       32'(cnt_oe),       32'd0);
        check({tag, ".busy"},         32'(busy),         32'd0);
        check({tag, ".cnt_load_val"}, 32'(cnt_load_val), 32'(lval));
    endtask

    // Present a command at a falling edge; it is taken at the next rising
    // edge (caller guarantees cmd_ready), after which the LOAD cycle begins.
    task automatic issue(input logic [W-1:0] s, input logic [W-1:0] e,
                         input logic [PW-1:0] p, input logic rl);
        cmd_start    = s;
        cmd_end      = e;
        cmd_prescale = p;
        cmd_reload   = rl;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_end = '0;
        cmd_prescale = '0;
        cmd_reload = 1'b0;
        abort = 1'b0;

        // Reset held for two cycles.
        cur_test = "reset";
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset", 8'd0);

        // One-shot 3 -> 6, prescale 0, then two HOLD cycles.
        cur_test = "oneshot";
        issue(8'd3, 8'd6, 8'd0, 1'b0);
        push_run(8'd3, 8'd6, 0, 1'b1, 8'd0, -1, 2);
        run_sb();

        // Accepted straight from HOLD: wrap 254 -> 1 with prescale 2.
        cur_test = "wrap";
        issue(8'd254, 8'd1, 8'd2, 1'b0);
        push_run(8'd254, 8'd1, 2, 1'b1, 8'd6, -1, 2);
        run_sb();

        // abort in HOLD clears the display.
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_idle("hold_abort", 8'd254);

        // Reload timer 0 -> 0, prescale 1: three periods back to back.
        cur_test = "reload";
        issue(8'd0, 8'd0, 8'd1, 1'b1);
        push_run(8'd0, 8'd0, 1, 1'b1, 8'd1, -1, 0);
        push_run(8'd0, 8'd0, 1, 1'b1, 8'd0, -1, 0);
        push_run(8'd0, 8'd0, 1, 1'b1, 8'd0, -1, 0);
        run_sb();
        // Abort during the fourth LOAD.
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("reload_abort.cnt_load", 32'(cnt_load), 32'd1);
        check("reload_abort.done",     32'(done),     32'd0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_idle("reload_abort", 8'd0);

        // 10 -> 20, prescale 3; a second command is held during COUNT.
        cur_test = "abort_tick";
        issue(8'd10, 8'd20, 8'd3, 1'b0);
        push_run(8'd10, 8'd20, 3, 1'b1, 8'd0, 7, 0);
        cmd_start    = 8'd99;
        cmd_end      = 8'd100;
        cmd_prescale = 8'd0;
        cmd_reload   = 1'b0;
        cmd_valid    = 1'b1;
        run_sb();
        // Cycle 8 is a tick with cnt_value=11: abort must suppress cnt_inc.
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_tick.cnt_value", 32'(cnt_value), 32'd11);
        check("abort_tick.cnt_inc",   32'(cnt_inc),   32'd0);
        check("abort_tick.done",      32'(done),      32'd0);
        check("abort_tick.busy",      32'(busy),      32'd1);
        check("abort_tick.cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_idle("abort_idle", 8'd10);
        // The held command is taken only now.
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cur_test = "held_cmd";
        push_run(8'd99, 8'd100, 0, 1'b1, 8'd11, 1, 0);
        run_sb();

        // Reset on the cycle that would have been tick + match.
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_tick.cnt_value", 32'(cnt_value), 32'd100);
        check("rst_tick.done",      32'(done),      32'd0);
        check("rst_tick.cnt_inc",   32'(cnt_inc),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("rst_after", 8'd0);
        check("rst_after.cnt_value", 32'(cnt_value), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_counter_sequencer
